// File: rtl/operand_sweep_gen_pkg.sv
// -----------------------------------------------------------------------------
// operand_sweep_gen_pkg
//   Definitions shared by the operand sweep generator, its interface and the
//   summator bench.
//   - state_e            : FSM state encoding, 3 bits (IDLE..DONE)
//   - pair_count_width() : width of the completed-pair counter for a given
//                          operand width. 2*reglength+1 bits, so the final
//                          count 2^(2*reglength) fits without wrapping.
// -----------------------------------------------------------------------------
package operand_sweep_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic int pair_count_width(input int rl);
        return 2 * rl + 1;
    endfunction

endpackage

// File: rtl/operand_sweep_gen_if.sv
// -----------------------------------------------------------------------------
// operand_sweep_gen_if
//   Bundle between the sweep generator (master) and the summator side (slave).
//   Signals:
//     start      : begin a sweep (slave -> master)
//     sum_ready  : summator result valid for the current pair (slave -> master)
//     r1, r2     : operands (master -> slave)
//     sum_clear  : one-cycle clear pulse ahead of each pair
//     pair_valid : r1/r2 stable and under evaluation
//     busy       : sweep in progress
//     done       : sweep complete, held until next start or reset
//     timeout    : sticky, some pair advanced without sum_ready
//     pair_count : pairs completed in the current sweep
//     dbg_state  : current FSM state, for observation only
//
//   Handshake: a pair is offered while pair_valid=1. The pair completes on the
//   first rising clock edge where pair_valid=1 and sum_ready=1 (or when the
//   hold window runs out). sum_ready is ignored whenever pair_valid=0.
// -----------------------------------------------------------------------------
interface operand_sweep_gen_if #(
    parameter int reglength = 3
);
    import operand_sweep_gen_pkg::*;

    localparam int PCW = pair_count_width(reglength);

    logic                 start;
    logic                 sum_ready;
    logic [reglength-1:0] r1;
    logic [reglength-1:0] r2;
    logic                 sum_clear;
    logic                 pair_valid;
    logic                 busy;
    logic                 done;
    logic                 timeout;
    logic [PCW-1:0]       pair_count;
    state_e               dbg_state;

    modport master (
        input  start, sum_ready,
        output r1, r2, sum_clear, pair_valid, busy, done, timeout,
               pair_count, dbg_state
    );

    modport slave (
        output start, sum_ready,
        input  r1, r2, sum_clear, pair_valid, busy, done, timeout,
               pair_count, dbg_state
    );

endinterface

// File: rtl/operand_sweep_gen_operand_counter.sv
// -----------------------------------------------------------------------------
// operand_sweep_gen_operand_counter
//   Nested operand counter: r2 is the inner loop, r1 the outer loop.
//   Ports:
//     i_clk, i_reset : clock, asynchronous active-high reset
//     i_clear        : return both operands to zero (has priority over i_inc)
//     i_inc          : step to the next pair
//     o_r1, o_r2     : current operands
//     o_last_pair    : both operands at their maximum value
//   The wrap of r2 into r1 is explicit; r1 is never stepped past its maximum
//   because the caller stops incrementing on the last pair.
// -----------------------------------------------------------------------------
module operand_sweep_gen_operand_counter #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_r1,
    output logic [W-1:0] o_r2,
    output logic         o_last_pair
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] r_r1;
    logic [W-1:0] r_r2;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_r1 <= '0;
            r_r2 <= '0;
        end else if (i_clear) begin
            r_r1 <= '0;
            r_r2 <= '0;
        end else if (i_inc) begin
            if (r_r2 != MAX_VAL) begin
                r_r2 <= r_r2 + W'(1);
            end else begin
                r_r2 <= '0;
                r_r1 <= r_r1 + W'(1);
            end
        end
    end

    assign o_r1        = r_r1;
    assign o_r2        = r_r2;
    assign o_last_pair = (r_r1 == MAX_VAL) && (r_r2 == MAX_VAL);

endmodule

// File: rtl/operand_sweep_gen.sv
// -----------------------------------------------------------------------------
// operand_sweep_gen
//   On-chip operand source for the summator. Walks every (r1, r2) pair of
//   width reglength (r2 inner, r1 outer), clears the summator before each
//   pair, offers the pair for at most HOLD_CYCLES cycles and advances on
//   sum_ready or on timeout.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high; clears all state
//     bus   : operand_sweep_gen_if master modport (see interface header)
//   Pair timing: LOAD (1) + HOLD (1..HOLD_CYCLES) + ADVANCE (1).
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module operand_sweep_gen
    import operand_sweep_gen_pkg::*;
#(
    parameter int reglength   = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    operand_sweep_gen_if.master   bus
);

    localparam int PCW  = pair_count_width(reglength);
    // One extra bit so HOLD_CYCLES=1 still yields a legal width.
    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    state_e            r_state;
    logic [HC_W-1:0]   r_hold_cnt;
    logic [PCW-1:0]    r_pair_count;
    logic              r_timeout;
    logic              r_sum_clear;
    logic              r_pair_valid;
    logic              r_busy;
    logic              r_done;

    logic [reglength-1:0] w_r1;
    logic [reglength-1:0] w_r2;
    logic                 w_last_pair;
    logic                 w_start_ok;
    logic                 w_clear;
    logic                 w_inc;

    // start only matters when no sweep is running.
    assign w_start_ok = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_clear    = w_start_ok;
    // On the last pair the operands stay put so DONE reports r1=r2=max.
    assign w_inc      = (r_state == ST_ADVANCE) && !w_last_pair;

    operand_sweep_gen_operand_counter #(
        .W (reglength)
    ) u_operand_counter (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_clear     (w_clear),
        .i_inc       (w_inc),
        .o_r1        (w_r1),
        .o_r2        (w_r2),
        .o_last_pair (w_last_pair)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_hold_cnt   <= '0;
            r_pair_count <= '0;
            r_timeout    <= 1'b0;
            r_sum_clear  <= 1'b0;
            r_pair_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sum_clear <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state      <= ST_LOAD;
                        r_pair_count <= '0;
                        r_timeout    <= 1'b0;
                        r_sum_clear  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state      <= ST_HOLD;
                    r_hold_cnt   <= HC_W'(HOLD_CYCLES - 1);
                    r_pair_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (bus.sum_ready) begin
                        r_state      <= ST_ADVANCE;
                        r_pair_valid <= 1'b0;
                    end else if (r_hold_cnt == '0) begin
                        r_state      <= ST_ADVANCE;
                        r_pair_valid <= 1'b0;
                        r_timeout    <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HC_W'(1);
                    end
                end
                ST_ADVANCE: begin
                    r_pair_count <= r_pair_count + PCW'(1);
                    if (w_last_pair) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= ST_LOAD;
                        r_sum_clear <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.r1         = w_r1;
    assign bus.r2         = w_r2;
    assign bus.sum_clear  = r_sum_clear;
    assign bus.pair_valid = r_pair_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.timeout    = r_timeout;
    assign bus.pair_count = r_pair_count;
    assign bus.dbg_state  = r_state;

endmodule
